vga_fb_arbiter: RTL
===================

Name: vga_fb_arbiter

Overview:
- Shares one single-port framebuffer RAM between two requesters:
  - the VGA scanout fetch, which has hard real-time priority;
  - the MyISA processor load/store port, which uses a valid/ready handshake.
- Sits between the processor memory-mapped bus, the vga pixel pipeline and the framebuffer RAM.
- Tracks the owner of each in-flight read so return data reaches the correct requester.
- Counts CPU stall cycles and flags excessive starvation.

Parameters:
- AW, 17: framebuffer address width.
- DW, 8: pixel (palette index) width.
- FB_WORDS, 76800: valid framebuffer depth (320x240). Addresses at or above this are out of range.
- MAX_WAIT, 15: CPU wait cycles before cpu_starve is set.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- disp_req  in  1  scanout read request, single-cycle.
- disp_addr  in  AW  scanout read address.
- disp_rdata  out  DW  scanout read data.
- disp_rvalid  out  1  disp_rdata valid.
- cpu_valid  in  1  CPU request pending.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_ready  out  1  CPU request accepted this cycle.
- cpu_rdata  out  DW  CPU read data.
- cpu_rvalid  out  1  cpu_rdata valid.
- cpu_err  out  1  one-cycle pulse: accepted request was out of range.
- cpu_starve  out  1  sticky: CPU waited more than MAX_WAIT cycles.
- stall_cnt  out  16  saturating count of CPU wait cycles.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, 1-cycle latency.

Behaviour:
- Reset (rst=0, asynchronous):
  - All registered outputs are 0: disp_rvalid, cpu_rvalid, cpu_err, cpu_starve, stall_cnt.
  - disp_rdata and cpu_rdata are 0.
  - Wait counter cleared; owner tag = NONE.
  - mem_en=0 while in reset.
- Grant, combinational per cycle, at most one RAM access per cycle:
  - disp_req=1: display granted. mem_en=1, mem_we=0, mem_addr=disp_addr. cpu_ready=0.
  - Else cpu_valid=1 with cpu_addr<FB_WORDS: CPU granted. mem_en=1, mem_we=cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata. cpu_ready=1.
  - Else cpu_valid=1 with cpu_addr>=FB_WORDS: cpu_ready=1, mem_en=0. cpu_err pulses in the next cycle.
  - Else: mem_en=0.
- Read-return pipeline, registered:
  - Owner tag is one of NONE, DISP, CPU, CPU_ERR, latched at each grant.
  - Next cycle with tag DISP: disp_rvalid=1, disp_rdata=mem_rdata.
  - Next cycle with tag CPU (read grant): cpu_rvalid=1, cpu_rdata=mem_rdata.
  - Next cycle with tag CPU_ERR on a read: cpu_rvalid=1, cpu_rdata=0.
  - Writes produce no rvalid.
  - Read latency from grant is exactly 1 cycle for both requesters.
- CPU handshake:
  - The CPU holds cpu_valid, cpu_we, cpu_addr and cpu_wdata stable until cpu_ready=1.
  - A new request may be presented in the cycle after acceptance; back-to-back throughput is 1 per cycle.
- Starvation:
  - The wait counter increments each cycle that cpu_valid=1 and cpu_ready=0. It clears on acceptance.
  - stall_cnt increments under the same condition and saturates at 16'hFFFF.
  - When the wait counter exceeds MAX_WAIT, cpu_starve is set to 1 and stays set until reset.
  - The display is never blocked.
- Boundaries:
  - Simultaneous disp_req and cpu_valid: display wins; the CPU retries the next cycle.
  - cpu_addr=FB_WORDS-1 is in range; cpu_addr=FB_WORDS is out of range.
  - disp_addr is not range-checked. The scanout guarantees it is in range.
  - Reset mid-access: the in-flight rvalid is dropped and the tag returns to NONE.

Decomposition:
- Package vga_fb_pkg holds:
  - owner_t enum: NONE, DISP, CPU, CPU_ERR;
  - constants FB_W=320, FB_H=240, FB_WORDS;
  - AW and DW defaults.
- One sub-module, fb_wait_monitor, contains the wait counter, stall_cnt saturation and sticky cpu_starve.

Test Plan:
1. CPU write 8'h5A to 17'h00010, then read 17'h00010 with no display traffic. Required: cpu_ready=1 on the first cycle of each request; cpu_rvalid=1 with cpu_rdata=8'h5A one cycle after the read is accepted.
2. disp_req and a CPU read asserted in the same cycle. Required: display granted; disp_rvalid one cycle later; cpu_ready=0 then 1 on the next cycle; stall_cnt=1.
3. disp_req asserted every cycle for 20 cycles while cpu_valid is held. Required: cpu_starve=1 from the cycle the wait count reaches 16; it stays 1 after the display releases and the CPU is accepted.
4. CPU read at 17'd76800. Required: cpu_ready=1 and mem_en=0 in the request cycle; cpu_err=1 and cpu_rvalid=1 with cpu_rdata=0 in the next cycle. A read at 17'd76799 accesses RAM normally.
5. rst driven low between a display grant and its return. Required: disp_rvalid stays 0; all outputs are 0 asynchronously.
6. 2000 interleaved display and CPU requests checked against a reference model. Required: every read matches the model and its rvalid goes to the correct requester.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// Shared types and geometry for the framebuffer arbiter slice.
// Owner tags identify who receives each RAM read return.
package vga_fb_pkg;

  localparam int FB_AW    = 17;
  localparam int FB_DW    = 8;
  localparam int FB_W     = 320;
  localparam int FB_H     = 240;
  localparam int FB_WORDS = FB_W * FB_H;

  typedef enum logic [1:0] {
    NONE,
    DISP,
    CPU,
    CPU_ERR
  } owner_t;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Requester-side bundle: scanout fetch plus CPU load/store handshake.
// master = requesters, slave = arbiter.
interface vga_fb_arbiter_if #(
  parameter int AW = vga_fb_pkg::FB_AW,
  parameter int DW = vga_fb_pkg::FB_DW
);
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_rdata;
  logic          disp_rvalid;

  logic          cpu_valid;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ready;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;
  logic          cpu_err;

  modport master (
    output disp_req, disp_addr, cpu_valid, cpu_we, cpu_addr, cpu_wdata,
    input  disp_rdata, disp_rvalid, cpu_ready, cpu_rdata, cpu_rvalid, cpu_err
  );

  modport slave (
    input  disp_req, disp_addr, cpu_valid, cpu_we, cpu_addr, cpu_wdata,
    output disp_rdata, disp_rvalid, cpu_ready, cpu_rdata, cpu_rvalid, cpu_err
  );
endinterface

// File: rtl/fb_wait_monitor.sv
// CPU wait tracking: per-request wait counter, saturating stall_cnt, sticky starve flag.
// Registered outputs, one cycle behind the observed wait; never applies backpressure.
module fb_wait_monitor #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_valid,
  input  logic        cpu_ready,
  output logic        cpu_starve,
  output logic [15:0] stall_cnt
);

  localparam int WW = $clog2(MAX_WAIT + 2);

  logic [WW-1:0] wait_cnt;
  logic          wait_cyc;
  logic          wait_sat;

  assign wait_cyc = cpu_valid & ~cpu_ready;
  assign wait_sat = (wait_cnt == WW'(MAX_WAIT + 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt   <= '0;
      stall_cnt  <= '0;
      cpu_starve <= 1'b0;
    end else begin
      if (cpu_valid && cpu_ready)
        wait_cnt <= '0;
      else if (wait_cyc && !wait_sat)
        wait_cnt <= wait_cnt + 1'b1;

      if (wait_cyc && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;

      // This wait cycle pushes the count past MAX_WAIT.
      if (wait_cyc && wait_cnt >= WW'(MAX_WAIT))
        cpu_starve <= 1'b1;
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scanout has absolute priority, CPU takes idle slots.
// Read data returns one cycle after grant; CPU stalls via cpu_ready while the display owns the RAM.
module vga_fb_arbiter #(
  parameter int AW       = vga_fb_pkg::FB_AW,
  parameter int DW       = vga_fb_pkg::FB_DW,
  parameter int FB_WORDS = vga_fb_pkg::FB_WORDS,
  parameter int MAX_WAIT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  vga_fb_arbiter_if.slave        bus,
  output logic                   cpu_starve,
  output logic [15:0]            stall_cnt,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  input  logic [DW-1:0]          mem_rdata
);

  import vga_fb_pkg::*;

  logic   in_range;
  logic   disp_gnt;
  logic   cpu_acc;
  logic   cpu_gnt;
  logic   cpu_oob;
  owner_t tag_d, tag_q;
  logic   rd_d, rd_q;

  assign in_range = (32'(bus.cpu_addr) < 32'(FB_WORDS));

  // Grant and RAM drive; everything is forced idle while reset is held.
  always_comb begin
    disp_gnt      = rst & bus.disp_req;
    cpu_acc       = rst & bus.cpu_valid & ~bus.disp_req;
    cpu_gnt       = cpu_acc & in_range;
    cpu_oob       = cpu_acc & ~in_range;
    bus.cpu_ready = cpu_acc;
    mem_en        = disp_gnt | cpu_gnt;
    mem_we        = cpu_gnt & bus.cpu_we;
    mem_addr      = disp_gnt ? bus.disp_addr : (cpu_gnt ? bus.cpu_addr : '0);
    mem_wdata     = cpu_gnt ? bus.cpu_wdata : '0;
  end

  always_comb begin
    tag_d = NONE;
    rd_d  = 1'b0;
    if (disp_gnt) begin
      tag_d = DISP;
      rd_d  = 1'b1;
    end else if (cpu_gnt) begin
      tag_d = CPU;
      rd_d  = ~bus.cpu_we;
    end else if (cpu_oob) begin
      tag_d = CPU_ERR;
      rd_d  = ~bus.cpu_we;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q <= NONE;
      rd_q  <= 1'b0;
    end else begin
      tag_q <= tag_d;
      rd_q  <= rd_d;
    end
  end

  // RAM data lands the cycle after grant, so returns are steered by the latched tag.
  always_comb begin
    bus.disp_rvalid = (tag_q == DISP);
    bus.disp_rdata  = (tag_q == DISP) ? mem_rdata : '0;
    bus.cpu_rvalid  = rd_q & ((tag_q == CPU) | (tag_q == CPU_ERR));
    bus.cpu_rdata   = (rd_q && tag_q == CPU) ? mem_rdata : '0;
    bus.cpu_err     = (tag_q == CPU_ERR);
  end

  fb_wait_monitor #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_monitor (
    .clk        (clk),
    .rst        (rst),
    .cpu_valid  (bus.cpu_valid),
    .cpu_ready  (bus.cpu_ready),
    .cpu_starve (cpu_starve),
    .stall_cnt  (stall_cnt)
  );

endmodule
